// File: rtl/multiply_add_seq.sv
// Sequential shift-add multiply-accumulate p = a*b + c, one partial product per clock.
// Optional ovf output (result exceeds WIDTH bits) is enabled by defining MULT_SEQ_OVF_EN.
module multiply_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] p
`ifdef MULT_SEQ_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [WIDTH-1:0]     b_reg, b_next;
    logic [WIDTH-1:0]     c_reg, c_next;
    logic [2*WIDTH-1:0]   p_reg, p_next;
    logic                 done_reg, done_next;
    logic                 busy_reg, busy_next;
    logic                 ovf_reg, ovf_next;
    logic [WIDTH-1:0]     pp;
    logic [WIDTH:0]       sum;

    // Partial product: multiplier gated by the current low bit of the shifting multiplicand.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = b_reg[gi] & acc_reg[0];
        end
    endgenerate

    assign sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, pp};

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        p_next     = p_reg;
        done_next  = 1'b0;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next   = {{WIDTH{1'b0}}, a};
                    b_next     = b;
                    c_next     = c;
                    cnt_next   = CW'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg != '0) begin
                    acc_next = {sum, acc_reg[WIDTH-1:1]};
                    cnt_next = cnt_reg - CW'(1);
                end
                if (cnt_reg <= CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                p_next     = acc_reg + {{WIDTH{1'b0}}, c_reg};
                ovf_next   = |p_next[2*WIDTH-1:WIDTH];
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == RUN) || (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            p_reg     <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            p_reg     <= p_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign p    = p_reg;

`ifdef MULT_SEQ_OVF_EN
    assign ovf = ovf_reg;
`else
    // Without the ovf port the flag register has no load and is trimmed.
    logic unused_ovf;
    assign unused_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_multiply_add_seq.sv
// Self-checking bench for multiply_add_seq: directed cases plus random ops against a*b+c.
module tb_multiply_add_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic [W-1:0]   a, b, c;
    logic [2*W-1:0] p;
`ifdef MULT_SEQ_OVF_EN
    logic           ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    multiply_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .a     (a),
        .b     (b),
        .c     (c),
        .p     (p)
`ifdef MULT_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: start sampled on the next edge (T); done must appear after edge T+W+1.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] tc, input bit chg, input bit verbose);
        logic [2*W-1:0] exp;
        int  n;
        bit  seen;
        exp = 32'(ta) * 32'(tb_) + 32'(tc);
        a = ta; b = tb_; c = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            check({tag, "_busy"}, 64'(busy), 64'(1));
            @(posedge clk); #1;
            n++;
            if (chg && n == 3) begin
                a = W'($urandom); b = W'($urandom); c = W'($urandom);
            end
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        check({tag, "_latency"}, 64'(n), 64'(W + 1));
        check({tag, "_p"}, 64'(p), 64'(exp));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
`ifdef MULT_SEQ_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp >= 32'h0001_0000));
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        if (verbose)
            $display("op %s: a=%0h b=%0h c=%0h p=%0h latency=%0d", tag, ta, tb_, tc, p, n);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rc;
        int dcyc[3];
        int nd;
        int k;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_p", 64'(p), 64'(0));
`ifdef MULT_SEQ_OVF_EN
        check("reset_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("basic", 16'd7, 16'd3, 16'd2, 0, 1);
        check("basic_const", 64'(p), 64'd23);
        run_op("divrt", 16'h1234, 16'h0007, 16'h0003, 0, 1);
        check("divrt_const", 64'(p), 64'h7F6F);
        run_op("allones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1);
        check("allones_const", 64'(p), 64'hFFFF_0000);
        run_op("b_zero", 16'h1234, 16'h0000, 16'h0055, 0, 1);
        run_op("a_zero", 16'h0000, 16'hBEEF, 16'h0042, 0, 1);
        run_op("opchg", 16'h00AB, 16'h0101, 16'h0009, 1, 1);

        // Start held high continuously: done every W+2 cycles, p stays 10
        a = 16'd2; b = 16'd5; c = 16'd0; start = 1'b1;
        nd = 0; k = 0;
        while (nd < 3 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (done) begin
                dcyc[nd] = cyc;
                check("hold_p", 64'(p), 64'd10);
                nd++;
            end
        end
        start = 1'b0;
        check("hold_count", 64'(nd), 64'd3);
        if (nd == 3) begin
            check("hold_period1", 64'(dcyc[1] - dcyc[0]), 64'(W + 2));
            check("hold_period2", 64'(dcyc[2] - dcyc[1]), 64'(W + 2));
        end
        $display("op hold: done cycles %0d %0d %0d", dcyc[0], dcyc[1], dcyc[2]);
        @(posedge clk); #1;

        // Reset at edge T+5 aborts the op
        a = 16'h0033; b = 16'h0044; c = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_p", 64'(p), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        $display("op abort: busy=%0b done=%0b p=%0h", busy, done, p);
        rst = 1'b0;
        run_op("after_rst", 16'h0102, 16'h0304, 16'h0506, 0, 1);

        // Random operations against the arithmetic model
        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '1;
                2: begin ra = '1; rb = '1; end
                default: ;
            endcase
            run_op("rand", ra, rb, rc, ($urandom_range(0, 3) == 0), (i % 100 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
